// File: rtl/dp_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : dp_mem_pkg
//  Description : Shared constants and types for the 1024x16 simple dual-port
//                RAM and the FIFO controller built around it.
//  Contents    : MEM_DW    - storage word width
//                MEM_AW    - storage address width
//                MEM_DEPTH - number of storage words
//                count_t   - occupancy type, wide enough to hold MEM_DEPTH
//  Revision    : 1.0 - initial release
// ============================================================================
package dp_mem_pkg;

    localparam int MEM_DW    = 16;
    localparam int MEM_AW    = 10;
    localparam int MEM_DEPTH = 1 << MEM_AW;

    // One extra bit so that a completely full memory is representable.
    typedef logic [MEM_AW:0] count_t;

endpackage : dp_mem_pkg
`default_nettype wire

// File: rtl/dp_mem_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Interface   : dp_mem_fifo_ctrl_if
//  Description : FIFO request/response bundle between a producer/consumer
//                (master) and the dp_mem_fifo_ctrl FIFO (slave).
//  Signals     : flush, wr_en, wr_dat, rd_en          master -> slave
//                rd_dat, rd_valid, full, empty,
//                almost_full, count, overflow,
//                underflow                            slave  -> master
//  Revision    : 1.0 - initial release
// ============================================================================
interface dp_mem_fifo_ctrl_if
    import dp_mem_pkg::*;
#(
    parameter int DW = MEM_DW
);

    logic          flush;
    logic          wr_en;
    logic [DW-1:0] wr_dat;
    logic          rd_en;
    logic [DW-1:0] rd_dat;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    count_t        count;
    logic          overflow;
    logic          underflow;

    modport master (
        output flush, wr_en, wr_dat, rd_en,
        input  rd_dat, rd_valid, full, empty, almost_full, count,
               overflow, underflow
    );

    modport slave (
        input  flush, wr_en, wr_dat, rd_en,
        output rd_dat, rd_valid, full, empty, almost_full, count,
               overflow, underflow
    );

endinterface : dp_mem_fifo_ctrl_if
`default_nettype wire

// File: rtl/simple_dp_mem.sv
`default_nettype none
// ============================================================================
//  Module      : simple_dp_mem
//  Description : Simple dual-port RAM, one write port and one synchronous
//                read port sharing a clock. Contents are never reset.
//  Ports       : clk     - clock
//                we      - write enable
//                wr_adr  - write address
//                dat_in  - write data
//                rd_adr  - read address, sampled every rising edge
//                dat_out - registered read data (one cycle after rd_adr)
//  Revision    : 1.0 - initial release
// ============================================================================
module simple_dp_mem
    import dp_mem_pkg::*;
#(
    parameter int DW = MEM_DW,
    parameter int AW = MEM_AW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_adr,
    input  logic [DW-1:0] dat_in,
    input  logic [AW-1:0] rd_adr,
    output logic [DW-1:0] dat_out
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_adr] <= dat_in;
        end
        dat_out <= mem[rd_adr];
    end

endmodule : simple_dp_mem
`default_nettype wire

// File: rtl/dp_mem_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dp_mem_fifo_ctrl
//  Description : Synchronous standard (non show-ahead) FIFO controller that
//                owns both ports of a simple_dp_mem. Keeps the pointers,
//                occupancy, status flags and sticky error flags.
//  Ports       : clk   - rising-edge clock
//                reset - asynchronous active-low reset
//                bus   - FIFO bundle (slave side):
//                        flush/wr_en/wr_dat/rd_en in,
//                        rd_dat/rd_valid/full/empty/almost_full/count/
//                        overflow/underflow out
//  Revision    : 1.0 - initial release
// ============================================================================
module dp_mem_fifo_ctrl
    import dp_mem_pkg::*;
#(
    parameter int DW        = MEM_DW,
    parameter int AW        = MEM_AW,
    parameter int AFULL_LVL = 1000
) (
    input  logic              clk,
    input  logic              reset,
    dp_mem_fifo_ctrl_if.slave bus
);

    localparam logic [AW:0] FULL_CNT  = (AW+1)'(2**AW);
    localparam logic [AW:0] AFULL_CNT = (AW+1)'(AFULL_LVL);

    logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [AW:0]   count_q,    count_d;
    logic          rd_valid_q, rd_valid_d;
    logic          ovf_q,      ovf_d;
    logic          unf_q,      unf_d;
    logic [DW-1:0] hold_q;
    logic [DW-1:0] mem_dout;
    logic [DW-1:0] rd_dat;
    logic          full;
    logic          empty;
    logic          wr_acc;
    logic          rd_acc;

    // Status comes only from registered occupancy, never from the requests.
    assign full   = (count_q == FULL_CNT);
    assign empty  = (count_q == '0);

    assign wr_acc = bus.wr_en & ~full  & ~bus.flush;
    assign rd_acc = bus.rd_en & ~empty & ~bus.flush;

    // Read address always follows rd_ptr; the RAM registers the word at the
    // accepting edge, so it is on dat_out exactly when rd_valid is high.
    simple_dp_mem #(
        .DW (DW),
        .AW (AW)
    ) u_mem (
        .clk     (clk),
        .we      (wr_acc),
        .wr_adr  (wr_ptr_q),
        .dat_in  (bus.wr_dat),
        .rd_adr  (rd_ptr_q),
        .dat_out (mem_dout)
    );

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        rd_valid_d = 1'b0;

        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr_d   = rd_ptr_q + 1'b1;
                rd_valid_d = 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (bus.wr_en & full) begin
                ovf_d = 1'b1;
            end
            if (bus.rd_en & empty) begin
                unf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            hold_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            hold_q     <= rd_dat;
        end
    end

    // Between reads the last delivered word is held stable; flush leaves it.
    assign rd_dat          = rd_valid_q ? mem_dout : hold_q;

    assign bus.rd_dat      = rd_dat;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.almost_full = (count_q >= AFULL_CNT);
    assign bus.count       = count_q;
    assign bus.overflow    = ovf_q;
    assign bus.underflow   = unf_q;

endmodule : dp_mem_fifo_ctrl
`default_nettype wire

// File: tb/tb_dp_mem_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dp_mem_fifo_ctrl
//  Description : Self-checking bench for dp_mem_fifo_ctrl. A queue-based
//                reference model of FIFO behaviour supplies every expected
//                value; scenarios run as tasks from one initial block.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dp_mem_fifo_ctrl;
    import dp_mem_pkg::*;

    localparam int AFULL = 1000;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    dp_mem_fifo_ctrl_if bus ();

    dp_mem_fifo_ctrl #(
        .DW        (MEM_DW),
        .AW        (MEM_AW),
        .AFULL_LVL (AFULL)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: stored words, sticky flags, pending output word.
    logic [15:0] mq[$];
    logic        m_ovf;
    logic        m_unf;
    logic        m_rv;
    logic [15:0] m_rdat;

    logic [32:0] obs;
    assign obs = {bus.rd_valid, bus.rd_dat, bus.count, bus.full, bus.empty,
                  bus.almost_full, bus.overflow, bus.underflow};

    function automatic logic [32:0] expv();
        int n;
        n = mq.size();
        return {m_rv, m_rdat, 11'(n), (n == MEM_DEPTH), (n == 0),
                (n >= AFULL), m_ovf, m_unf};
    endfunction

    task automatic model_clear();
        mq.delete();
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_rv   = 1'b0;
        m_rdat = 16'h0;
    endtask

    // One clock cycle: drive requests, let the edge happen, advance the model.
    task automatic step(input logic f, input logic w, input logic [15:0] d,
                        input logic r);
        int n;
        bus.flush  = f;
        bus.wr_en  = w;
        bus.wr_dat = d;
        bus.rd_en  = r;
        @(posedge clk);
        n    = mq.size();
        m_rv = 1'b0;
        if (f) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (w && n == MEM_DEPTH) m_ovf = 1'b1;
            if (r && n == 0)         m_unf = 1'b1;
            if (r && n != 0) begin
                m_rdat = mq.pop_front();
                m_rv   = 1'b1;
            end
            if (w && n != MEM_DEPTH) mq.push_back(d);
        end
        #1;
        bus.flush = 1'b0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    task automatic do_reset();
        bus.flush  = 1'b0;
        bus.wr_en  = 1'b0;
        bus.rd_en  = 1'b0;
        bus.wr_dat = 16'h0;
        rst_n      = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if (bus.count !== 11'd0) $display("FAIL reset_count: got %0d expected 0", bus.count);
        else n_pass++;
        n_total++;
        if (bus.empty !== 1'b1) $display("FAIL reset_empty: got %b expected 1", bus.empty);
        else n_pass++;
        n_total++;
        if ({bus.full, bus.almost_full, bus.overflow, bus.underflow, bus.rd_valid} !== 5'b0)
            $display("FAIL reset_flags: got %b expected 00000",
                     {bus.full, bus.almost_full, bus.overflow, bus.underflow, bus.rd_valid});
        else n_pass++;
        n_total++;
        if (bus.rd_dat !== 16'h0) $display("FAIL reset_rd_dat: got %h expected 0000", bus.rd_dat);
        else n_pass++;
    endtask

    task automatic test_basic();
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b1, 16'(i), 1'b0);
            n_total++;
            if (bus.count !== 11'(i)) $display("FAIL basic_wr_count[%0d]: got %0d expected %0d", i, bus.count, i);
            else n_pass++;
        end
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b0, 16'h0, 1'b1);
            n_total++;
            if ({bus.rd_valid, bus.rd_dat} !== {1'b1, 16'(i)})
                $display("FAIL basic_rd[%0d]: got valid=%b dat=%h expected valid=1 dat=%h",
                         i, bus.rd_valid, bus.rd_dat, 16'(i));
            else n_pass++;
            n_total++;
            if (obs !== expv()) $display("FAIL basic_model[%0d]: got %h expected %h", i, obs, expv());
            else n_pass++;
        end
        step(1'b0, 1'b0, 16'h0, 1'b0);
        n_total++;
        if ({bus.rd_valid, bus.rd_dat, bus.empty, bus.count} !== {1'b0, 16'h0004, 1'b1, 11'd0})
            $display("FAIL basic_idle: got valid=%b dat=%h empty=%b count=%0d expected valid=0 dat=0004 empty=1 count=0",
                     bus.rd_valid, bus.rd_dat, bus.empty, bus.count);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'($urandom), 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b1);
        n_total++;
        if (bus.rd_valid !== 1'b1) $display("FAIL areset_pre_valid: got %b expected 1", bus.rd_valid);
        else n_pass++;
        #2 rst_n = 1'b0;
        model_clear();
        #1;
        n_total++;
        if (obs !== expv()) $display("FAIL areset_immediate: got %h expected %h", obs, expv());
        else n_pass++;
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic test_fill();
        int errs;
        errs = 0;
        step(1'b1, 1'b0, 16'h0, 1'b0);
        for (int k = 1; k <= MEM_DEPTH; k++) begin
            step(1'b0, 1'b1, 16'($urandom), 1'b0);
            n_total++;
            if (obs !== expv()) $display("FAIL fill_model[%0d]: got %h expected %h", k, obs, expv());
            else n_pass++;
            if (k == AFULL - 1 || k == AFULL) begin
                n_total++;
                if (bus.almost_full !== (k == AFULL))
                    $display("FAIL fill_afull[%0d]: got %b expected %b", k, bus.almost_full, (k == AFULL));
                else n_pass++;
            end
        end
        n_total++;
        if ({bus.full, bus.count} !== {1'b1, 11'd1024})
            $display("FAIL fill_full: got full=%b count=%0d expected full=1 count=1024", bus.full, bus.count);
        else n_pass++;
        step(1'b0, 1'b1, 16'hDEAD, 1'b0);
        n_total++;
        if ({bus.overflow, bus.count} !== {1'b1, 11'd1024})
            $display("FAIL fill_overflow: got ovf=%b count=%0d expected ovf=1 count=1024", bus.overflow, bus.count);
        else n_pass++;
        for (int k = 0; k < MEM_DEPTH; k++) begin
            step(1'b0, 1'b0, 16'h0, 1'b1);
            n_total++;
            if (obs !== expv()) begin
                errs++;
                if (errs <= 10) $display("FAIL drain_model[%0d]: got %h expected %h", k, obs, expv());
            end else n_pass++;
        end
    endtask

    task automatic test_underflow();
        step(1'b0, 1'b0, 16'h0, 1'b1);
        n_total++;
        if ({bus.underflow, bus.rd_valid, bus.count} !== {1'b1, 1'b0, 11'd0})
            $display("FAIL underflow: got unf=%b valid=%b count=%0d expected unf=1 valid=0 count=0",
                     bus.underflow, bus.rd_valid, bus.count);
        else n_pass++;
        step(1'b0, 1'b1, 16'hBEEF, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b1);
        n_total++;
        if ({bus.rd_valid, bus.rd_dat} !== {1'b1, 16'hBEEF})
            $display("FAIL underflow_beef: got valid=%b dat=%h expected valid=1 dat=beef", bus.rd_valid, bus.rd_dat);
        else n_pass++;
        n_total++;
        if (obs !== expv()) $display("FAIL underflow_model: got %h expected %h", obs, expv());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int errs;
        errs = 0;
        step(1'b1, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 512; i++) step(1'b0, 1'b1, 16'(i), 1'b0);
        for (int i = 0; i < 2000; i++) begin
            step(1'b0, 1'b1, 16'(512 + i), 1'b1);
            n_total++;
            if ({bus.count, bus.rd_valid, bus.rd_dat} !== {11'd512, 1'b1, 16'(i)} || obs !== expv()) begin
                errs++;
                if (errs <= 10)
                    $display("FAIL b2b[%0d]: got count=%0d valid=%b dat=%h expected count=512 valid=1 dat=%h",
                             i, bus.count, bus.rd_valid, bus.rd_dat, 16'(i));
            end else n_pass++;
        end
    endtask

    task automatic test_full_rw();
        step(1'b1, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < MEM_DEPTH; i++) step(1'b0, 1'b1, 16'($urandom), 1'b0);
        step(1'b0, 1'b1, 16'h7777, 1'b1);
        n_total++;
        if ({bus.overflow, bus.count, bus.rd_valid} !== {1'b1, 11'd1023, 1'b1})
            $display("FAIL full_rw: got ovf=%b count=%0d valid=%b expected ovf=1 count=1023 valid=1",
                     bus.overflow, bus.count, bus.rd_valid);
        else n_pass++;
        n_total++;
        if (obs !== expv()) $display("FAIL full_rw_model: got %h expected %h", obs, expv());
        else n_pass++;
    endtask

    task automatic test_flush();
        // Leaves overflow set from the previous scenario; drain down to 5.
        for (int i = 0; i < 1018; i++) step(1'b0, 1'b0, 16'h0, 1'b1);
        n_total++;
        if ({bus.count, bus.rd_valid, bus.overflow} !== {11'd5, 1'b1, 1'b1})
            $display("FAIL flush_pre: got count=%0d valid=%b ovf=%b expected count=5 valid=1 ovf=1",
                     bus.count, bus.rd_valid, bus.overflow);
        else n_pass++;
        step(1'b1, 1'b1, 16'h5555, 1'b1);
        n_total++;
        if ({bus.count, bus.empty, bus.overflow, bus.underflow, bus.rd_valid} !== {11'd0, 1'b1, 1'b0, 1'b0, 1'b0})
            $display("FAIL flush_post: got count=%0d empty=%b ovf=%b unf=%b valid=%b expected 0 1 0 0 0",
                     bus.count, bus.empty, bus.overflow, bus.underflow, bus.rd_valid);
        else n_pass++;
        n_total++;
        if (obs !== expv()) $display("FAIL flush_model: got %h expected %h", obs, expv());
        else n_pass++;
        step(1'b0, 1'b1, 16'h1234, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b1);
        n_total++;
        if ({bus.rd_valid, bus.rd_dat, bus.count} !== {1'b1, 16'h1234, 11'd0})
            $display("FAIL flush_newword: got valid=%b dat=%h count=%0d expected valid=1 dat=1234 count=0",
                     bus.rd_valid, bus.rd_dat, bus.count);
        else n_pass++;
    endtask

    task automatic test_random();
        int errs;
        logic f, w, r;
        errs = 0;
        for (int i = 0; i < 3000; i++) begin
            f = ($urandom_range(0, 999) == 0);
            if ((i / 500) % 2 == 0) begin
                w = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 3) == 0);
            end else begin
                w = ($urandom_range(0, 3) == 0);
                r = ($urandom_range(0, 3) != 0);
            end
            step(f, w, 16'($urandom), r);
            n_total++;
            if (obs !== expv()) begin
                errs++;
                if (errs <= 10) $display("FAIL random[%0d]: got %h expected %h", i, obs, expv());
            end else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_async_reset();
        test_fill();
        test_underflow();
        test_back_to_back();
        test_full_rw();
        test_flush();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule : tb_dp_mem_fifo_ctrl
`default_nettype wire
